// File: rtl/micro_mult_pkg.sv
// Shared types, default widths and operand-extension helper for the micro multiplier tile.
package micro_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_ACC_W = 8;

   // Fill bit used above the operand MSB: sign copy for signed, zero for unsigned.
   function automatic logic ext_fill(input logic msb, input logic signed_mode);
      return signed_mode & msb;
   endfunction

endpackage

// File: rtl/micro_mult_step.sv
// One combinational shift-add step; the last multiplier bit subtracts in signed mode
// because it carries negative weight in two's complement.
module micro_mult_step #(
   parameter int ACC_W = 8,
   parameter int IDX_W = 2
) (
   input  logic signed [ACC_W-1:0] partial,
   input  logic signed [ACC_W-1:0] ext_a,
   input  logic        [IDX_W-1:0] bit_idx,
   input  logic                    b_bit,
   input  logic                    last,
   input  logic                    signed_mode,
   output logic signed [ACC_W-1:0] next_partial
);

   logic signed [ACC_W-1:0] shifted;

   assign shifted = ext_a <<< bit_idx;

   always_comb begin
      next_partial = partial;
      if (b_bit) begin
         if (last && signed_mode) begin
            next_partial = partial - shifted;
         end else begin
            next_partial = partial + shifted;
         end
      end
   end

endmodule

// File: rtl/micro_mult_seq.sv
// Sequential shift-add multiplier / MAC: one multiplier bit per clock, valid/ready on
// both sides, optional accumulation into an internal accumulator.
module micro_mult_seq
   import micro_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic             busy
);

   localparam int IDX_W = $clog2(WIDTH);

   state_t                  state_q, state_d;
   logic        [IDX_W-1:0] cnt_q;
   logic        [WIDTH-1:0] b_q;
   logic signed [ACC_W-1:0] a_ext_q;
   logic signed [ACC_W-1:0] partial_q, partial_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] result_q;
   logic                    sgn_q, acc_en_q, acc_clr_q;
   logic                    last_bit;

   assign last_bit = (cnt_q == IDX_W'(WIDTH - 1));

   // b_q is shifted right each RUN edge, so bit 0 is always the current multiplier bit.
   micro_mult_step #(
      .ACC_W(ACC_W),
      .IDX_W(IDX_W)
   ) u_step (
      .partial     (partial_q),
      .ext_a       (a_ext_q),
      .bit_idx     (cnt_q),
      .b_bit       (b_q[0]),
      .last        (last_bit),
      .signed_mode (sgn_q),
      .next_partial(partial_d)
   );

   always_comb begin
      acc_d = acc_clr_q ? partial_d : acc_q + partial_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_bit)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_ext_q   <= {{(ACC_W - WIDTH){ext_fill(a[WIDTH-1], signed_mode)}}, a};
                  b_q       <= b;
                  sgn_q     <= signed_mode;
                  acc_en_q  <= acc_en;
                  acc_clr_q <= acc_clr;
                  partial_q <= '0;
                  cnt_q     <= '0;
               end
            end
            RUN: begin
               partial_q <= partial_d;
               b_q       <= b_q >> 1;
               cnt_q     <= cnt_q + 1'b1;
               // Final bit: publish the product, folding it into the accumulator in MAC mode.
               if (last_bit) begin
                  if (acc_en_q) begin
                     acc_q    <= acc_d;
                     result_q <= acc_d;
                  end else begin
                     result_q <= partial_d;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
